// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared types and helpers for the game-flow controller.
//   game_state_t    : top-level game states
//   lives_width     : bits needed to hold a lives count 0..lives
//   level_width     : bits needed to index n items (at least 1 bit)
//   frame_width     : bits needed to hold the largest frame limit
//   frames_per_tick : frames per snake move at a given level, floored
//   DEF_*           : default parameter values and the widths they imply
// ---------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_RESPAWN,
        ST_OVER,
        ST_WIN
    } game_state_t;

    localparam int DEF_LIVES            = 3;
    localparam int DEF_SCORE_W          = 8;
    localparam int DEF_LEVELS           = 4;
    localparam int DEF_APPLES_PER_LEVEL = 5;
    localparam int DEF_BASE_FRAMES      = 16;
    localparam int DEF_FRAME_STEP       = 3;
    localparam int DEF_MIN_FRAMES       = 2;
    localparam int DEF_RESPAWN_FRAMES   = 60;

    function automatic int lives_width(input int lives);
        return $clog2(lives + 1);
    endfunction

    function automatic int level_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width large enough to reach any limit the controller uses.
    function automatic int frame_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

    // Signed subtraction so a high level with a large step cannot wrap
    // around to a huge period; the floor keeps the game playable.
    function automatic int frames_per_tick(input int level, input int base,
                                           input int step, input int min_frames);
        int p;
        p = base - level * step;
        return (p < min_frames) ? min_frames : p;
    endfunction

    localparam int DEF_LIVES_W = lives_width(DEF_LIVES);
    localparam int DEF_LEVEL_W = level_width(DEF_LEVELS);
    localparam int DEF_FRAME_W = frame_width(DEF_BASE_FRAMES, DEF_MIN_FRAMES,
                                             DEF_RESPAWN_FRAMES);

endpackage

// File: rtl/game_flow_if.sv
// ---------------------------------------------------------------------------
// game_flow_if
// Bundles the game-flow controller's event inputs and status outputs.
//   i_restart, i_start, i_pause        : player/control requests
//   i_vsync_pulse                      : one pulse per video frame
//   i_tick_done, i_eat                 : snake/apple events
//   i_snake_failure, i_snake_success   : end-of-round conditions
//   o_tick                             : move request to the snake
//   o_running/o_paused/o_failure/o_success : state flags
//   o_lose_life                        : one-cycle re-init pulse
//   o_lives, o_level, o_score, o_high_score : counters for display
// Modport master drives the inputs (game top level / bench), slave is the
// controller itself.
// ---------------------------------------------------------------------------
interface game_flow_if
    import game_pkg::*;
#(
    parameter int LIVES   = DEF_LIVES,
    parameter int LEVELS  = DEF_LEVELS,
    parameter int SCORE_W = DEF_SCORE_W
);
    localparam int LIVES_W = lives_width(LIVES);
    localparam int LEVEL_W = level_width(LEVELS);

    logic               i_restart;
    logic               i_start;
    logic               i_pause;
    logic               i_vsync_pulse;
    logic               i_tick_done;
    logic               i_eat;
    logic               i_snake_failure;
    logic               i_snake_success;
    logic               o_tick;
    logic               o_running;
    logic               o_paused;
    logic               o_lose_life;
    logic               o_failure;
    logic               o_success;
    logic [LIVES_W-1:0] o_lives;
    logic [LEVEL_W-1:0] o_level;
    logic [SCORE_W-1:0] o_score;
    logic [SCORE_W-1:0] o_high_score;

    modport master (
        output i_restart, i_start, i_pause, i_vsync_pulse, i_tick_done,
               i_eat, i_snake_failure, i_snake_success,
        input  o_tick, o_running, o_paused, o_lose_life, o_failure,
               o_success, o_lives, o_level, o_score, o_high_score
    );

    modport slave (
        input  i_restart, i_start, i_pause, i_vsync_pulse, i_tick_done,
               i_eat, i_snake_failure, i_snake_success,
        output o_tick, o_running, o_paused, o_lose_life, o_failure,
               o_success, o_lives, o_level, o_score, o_high_score
    );

endinterface

// File: rtl/frame_divider.sv
// ---------------------------------------------------------------------------
// frame_divider
// Counts enabled frame pulses up to a limit that may change at runtime.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : synchronous clear of the count
//   en_i     : count this cycle (a qualified vsync pulse)
//   limit_i  : number of pulses per period (>= 1)
//   hit_o    : combinational, high on the pulse that completes the period;
//              the count restarts from zero on that same pulse
// ---------------------------------------------------------------------------
module frame_divider #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         hit_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W:0]   countNext;

    // The period ends on the pulse that brings the count up to the limit.
    // Comparing with >= in one extra bit also copes with the limit being
    // lowered below the current count (a level-up mid-period), so a shrunk
    // period ends on the next pulse instead of running past it.
    always_comb begin
        countNext = (W+1)'(count_q) + (W+1)'(1);
        hit_o     = en_i && !clr_i && (countNext >= {1'b0, limit_i});
        count_d   = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = hit_o ? '0 : countNext[W-1:0];
        end
    end

    // Plain count register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/game_flow.sv
// ---------------------------------------------------------------------------
// game_flow
// Game-flow controller: generates the snake move tick from vsync, handles
// start/pause/respawn/game-over/win, and keeps lives, score, level and the
// high score.
//   clk, rst : clock, synchronous active-high reset (also clears high score)
//   bus      : game_flow_if.slave -- event inputs and status outputs
// ---------------------------------------------------------------------------
module game_flow
    import game_pkg::*;
#(
    parameter int LIVES            = DEF_LIVES,
    parameter int SCORE_W          = DEF_SCORE_W,
    parameter int LEVELS           = DEF_LEVELS,
    parameter int APPLES_PER_LEVEL = DEF_APPLES_PER_LEVEL,
    parameter int BASE_FRAMES      = DEF_BASE_FRAMES,
    parameter int FRAME_STEP       = DEF_FRAME_STEP,
    parameter int MIN_FRAMES       = DEF_MIN_FRAMES,
    parameter int RESPAWN_FRAMES   = DEF_RESPAWN_FRAMES
) (
    input  logic       clk,
    input  logic       rst,
    game_flow_if.slave bus
);

    localparam int LIVES_W = lives_width(LIVES);
    localparam int LEVEL_W = level_width(LEVELS);
    localparam int APPLE_W = level_width(APPLES_PER_LEVEL);
    localparam int FRAME_W = frame_width(BASE_FRAMES, MIN_FRAMES, RESPAWN_FRAMES);

    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(LEVELS - 1);
    localparam logic [APPLE_W-1:0] APPLE_LAST = APPLE_W'(APPLES_PER_LEVEL - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [FRAME_W-1:0] RESPAWN_LIMIT = FRAME_W'(RESPAWN_FRAMES);

    game_state_t        state_q, state_d;
    logic               tick_q, tick_d;
    logic               loseLife_q, loseLife_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [APPLE_W-1:0] apple_q, apple_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] highScore_q, highScore_d;
    logic               pause_q;

    logic               inPlay;
    logic               pauseRise;
    logic               tickEn, tickClr, tickHit;
    logic               respawnEn, respawnClr, respawnHit;
    logic [FRAME_W-1:0] tickLimit;
    logic               endState;

    // Divider controls. The tick period only advances while running with no
    // move outstanding, so a done and a vsync in the same cycle never count
    // that vsync. Leaving play (respawn, over, win, idle) discards any
    // partial period.
    always_comb begin
        inPlay     = (state_q == ST_RUN) || (state_q == ST_PAUSE);
        tickEn     = bus.i_vsync_pulse && (state_q == ST_RUN) && !tick_q;
        tickClr    = bus.i_restart || !inPlay;
        tickLimit  = FRAME_W'(frames_per_tick(int'(level_q), BASE_FRAMES,
                                              FRAME_STEP, MIN_FRAMES));
        respawnEn  = bus.i_vsync_pulse && (state_q == ST_RESPAWN);
        respawnClr = bus.i_restart || (state_q != ST_RESPAWN);
    end

    frame_divider #(.W(FRAME_W)) tickDiv (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (tickClr),
        .en_i    (tickEn),
        .limit_i (tickLimit),
        .hit_o   (tickHit)
    );

    frame_divider #(.W(FRAME_W)) respawnDiv (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (respawnClr),
        .en_i    (respawnEn),
        .limit_i (RESPAWN_LIMIT),
        .hit_o   (respawnHit)
    );

    // Next-state logic. Eats are handled before the state case so an apple
    // eaten in the same cycle as a win, loss or pause still scores. Inside
    // RUN the order success > failure > pause edge sets the priority.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        loseLife_d  = 1'b0;
        lives_d     = lives_q;
        level_d     = level_q;
        apple_d     = apple_q;
        score_d     = score_q;
        highScore_d = highScore_q;
        pauseRise   = bus.i_pause && !pause_q;

        if (tick_q && bus.i_tick_done) begin
            tick_d = 1'b0;
        end else if (tickHit) begin
            tick_d = 1'b1;
        end

        if (bus.i_eat && inPlay) begin
            if (score_q != SCORE_MAX) begin
                score_d = score_q + SCORE_W'(1);
            end
            if (apple_q == APPLE_LAST) begin
                apple_d = '0;
                if (level_q != LEVEL_LAST) begin
                    level_d = level_q + LEVEL_W'(1);
                end
            end else begin
                apple_d = apple_q + APPLE_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.i_snake_success) begin
                    state_d = ST_WIN;
                end else if (bus.i_snake_failure) begin
                    if (lives_q <= LIVES_W'(1)) begin
                        state_d = ST_OVER;
                        lives_d = '0;
                    end else begin
                        state_d    = ST_RESPAWN;
                        lives_d    = lives_q - LIVES_W'(1);
                        loseLife_d = 1'b1;
                    end
                end else if (pauseRise) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pauseRise) begin
                    state_d = ST_RUN;
                end
            end
            ST_RESPAWN: begin
                if (respawnHit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OVER, ST_WIN: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A pending move is dropped whenever play stops for good or for a
        // respawn; the snake is being re-initialised anyway.
        if ((state_d == ST_RESPAWN) || (state_d == ST_OVER) || (state_d == ST_WIN)) begin
            tick_d = 1'b0;
        end

        // The high score is only folded in once, on the way into a final
        // state, and uses the score including any same-cycle eat.
        endState = (state_q == ST_OVER) || (state_q == ST_WIN);
        if (!endState && ((state_d == ST_OVER) || (state_d == ST_WIN))) begin
            highScore_d = (score_d > highScore_q) ? score_d : highScore_q;
        end
    end

    // State register. Reset and restart share every clear except the high
    // score, which only a full reset wipes. The pause edge register always
    // follows the button, including during reset, so a button held across
    // reset or restart is not seen as a new press.
    always_ff @(posedge clk) begin
        pause_q <= bus.i_pause;
        if (rst || bus.i_restart) begin
            state_q    <= ST_IDLE;
            tick_q     <= 1'b0;
            loseLife_q <= 1'b0;
            lives_q    <= LIVES_INIT;
            level_q    <= '0;
            apple_q    <= '0;
            score_q    <= '0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            loseLife_q <= loseLife_d;
            lives_q    <= lives_d;
            level_q    <= level_d;
            apple_q    <= apple_d;
            score_q    <= score_d;
        end
        if (rst) begin
            highScore_q <= '0;
        end else if (!bus.i_restart) begin
            highScore_q <= highScore_d;
        end
    end

    // Status outputs come straight from registers or a decode of the state
    // register, so they change only on the clock edge.
    always_comb begin
        bus.o_tick       = tick_q;
        bus.o_lose_life  = loseLife_q;
        bus.o_running    = (state_q == ST_RUN);
        bus.o_paused     = (state_q == ST_PAUSE);
        bus.o_failure    = (state_q == ST_OVER);
        bus.o_success    = (state_q == ST_WIN);
        bus.o_lives      = lives_q;
        bus.o_level      = level_q;
        bus.o_score      = score_q;
        bus.o_high_score = highScore_q;
    end

endmodule

// File: tb/tb_game_flow.sv
// ---------------------------------------------------------------------------
// tb_game_flow
// Directed bench for game_flow with default parameters. Inputs change on the
// falling edge and outputs are read on the falling edge, half a cycle after
// the rising edge that updated them.
// ---------------------------------------------------------------------------
module tb_game_flow;
    import game_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    game_flow_if #(.LIVES(3), .LEVELS(4), .SCORE_W(8)) bus ();

    game_flow dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stimulus helpers: all start and end on a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseVsync();
        bus.i_vsync_pulse = 1'b1;
        @(negedge clk);
        bus.i_vsync_pulse = 1'b0;
    endtask

    task automatic pulseStart();
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic pulseEat(input int n);
        for (int i = 0; i < n; i++) begin
            bus.i_eat = 1'b1;
            @(negedge clk);
            bus.i_eat = 1'b0;
        end
    endtask

    task automatic pulseFailure();
        bus.i_snake_failure = 1'b1;
        @(negedge clk);
        bus.i_snake_failure = 1'b0;
    endtask

    // One frame with an obliging snake: a raised tick is answered at once.
    task automatic vsyncFrame(output bit sawTick);
        pulseVsync();
        sawTick = bus.o_tick;
        if (sawTick) begin
            bus.i_tick_done = 1'b1;
            @(negedge clk);
            bus.i_tick_done = 1'b0;
        end
    endtask

    // Frames up to and including the one that raised a tick; -1 if none.
    task automatic framesToTick(output int n);
        bit saw;
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            vsyncFrame(saw);
            if (saw) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic loseLifeAndRespawn();
        pulseFailure();
        repeat (60) pulseVsync();
        pulseStart();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        checks++; if (bus.o_running !== 1'b0 || bus.o_paused !== 1'b0 || bus.o_failure !== 1'b0 || bus.o_success !== 1'b0) begin errors++; $display("[TB] FAIL reset_state: got run=%b pause=%b over=%b win=%b want all 0", bus.o_running, bus.o_paused, bus.o_failure, bus.o_success); end
        checks++; if (bus.o_tick !== 1'b0 || bus.o_lose_life !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses: got tick=%b lose=%b want 0 0", bus.o_tick, bus.o_lose_life); end
        checks++; if (bus.o_lives !== 2'd3) begin errors++; $display("[TB] FAIL reset_lives: got %0d want 3", bus.o_lives); end
        checks++; if (bus.o_level !== 2'd0 || bus.o_score !== 8'd0 || bus.o_high_score !== 8'd0) begin errors++; $display("[TB] FAIL reset_counts: got level=%0d score=%0d high=%0d want 0 0 0", bus.o_level, bus.o_score, bus.o_high_score); end
        pulseEat(1);
        checks++; if (bus.o_score !== 8'd0) begin errors++; $display("[TB] FAIL idle_eat_ignored: got %0d want 0", bus.o_score); end
        bus.i_pause = 1'b1;
        @(negedge clk);
        bus.i_pause = 1'b0;
        @(negedge clk);
        checks++; if (bus.o_paused !== 1'b0) begin errors++; $display("[TB] FAIL idle_pause_ignored: got %b want 0", bus.o_paused); end
    endtask

    task automatic test_tick_period();
        int n;
        bit saw;
        pulseStart();
        checks++; if (bus.o_running !== 1'b1) begin errors++; $display("[TB] FAIL start_running: got %b want 1", bus.o_running); end
        framesToTick(n);
        checks++; if (n !== 16) begin errors++; $display("[TB] FAIL first_period: got %0d want 16", n); end
        framesToTick(n);
        checks++; if (n !== 16) begin errors++; $display("[TB] FAIL second_period: got %0d want 16", n); end
        // Let the tick rise and hold it with no done.
        for (int i = 0; i < 15; i++) vsyncFrame(saw);
        pulseVsync();
        checks++; if (bus.o_tick !== 1'b1) begin errors++; $display("[TB] FAIL tick_raised: got %b want 1", bus.o_tick); end
        pulseVsync();
        checks++; if (bus.o_tick !== 1'b1) begin errors++; $display("[TB] FAIL tick_held: got %b want 1", bus.o_tick); end
        // Done and vsync together: tick clears and this vsync is not counted.
        bus.i_vsync_pulse = 1'b1;
        bus.i_tick_done   = 1'b1;
        @(negedge clk);
        bus.i_vsync_pulse = 1'b0;
        bus.i_tick_done   = 1'b0;
        checks++; if (bus.o_tick !== 1'b0) begin errors++; $display("[TB] FAIL done_clears: got %b want 0", bus.o_tick); end
        framesToTick(n);
        checks++; if (n !== 16) begin errors++; $display("[TB] FAIL done_vsync_period: got %0d want 16", n); end
    endtask

    task automatic test_pause();
        int n;
        int ticks;
        bit saw;
        ticks = 0;
        for (int i = 0; i < 7; i++) begin vsyncFrame(saw); if (saw) ticks++; end
        bus.i_pause = 1'b1;
        @(negedge clk);
        checks++; if (bus.o_paused !== 1'b1 || bus.o_running !== 1'b0) begin errors++; $display("[TB] FAIL pause_enter: got paused=%b run=%b want 1 0", bus.o_paused, bus.o_running); end
        for (int i = 0; i < 30; i++) begin vsyncFrame(saw); if (saw) ticks++; end
        checks++; if (ticks !== 0) begin errors++; $display("[TB] FAIL pause_no_ticks: got %0d want 0", ticks); end
        bus.i_pause = 1'b0;
        @(negedge clk);
        checks++; if (bus.o_paused !== 1'b1) begin errors++; $display("[TB] FAIL pause_release_holds: got %b want 1", bus.o_paused); end
        bus.i_pause = 1'b1;
        @(negedge clk);
        checks++; if (bus.o_running !== 1'b1) begin errors++; $display("[TB] FAIL pause_exit: got %b want 1", bus.o_running); end
        framesToTick(n);
        checks++; if (n !== 9) begin errors++; $display("[TB] FAIL pause_resume_period: got %0d want 9", n); end
        bus.i_pause = 1'b0;
        @(negedge clk);
        checks++; if (bus.o_running !== 1'b1) begin errors++; $display("[TB] FAIL pause_fall_no_effect: got %b want 1", bus.o_running); end
    endtask

    task automatic test_eat_levels();
        int n;
        pulseEat(5);
        checks++; if (bus.o_score !== 8'd5 || bus.o_level !== 2'd1) begin errors++; $display("[TB] FAIL eat5: got score=%0d level=%0d want 5 1", bus.o_score, bus.o_level); end
        framesToTick(n);
        checks++; if (n !== 13) begin errors++; $display("[TB] FAIL level1_period: got %0d want 13", n); end
        pulseEat(15);
        checks++; if (bus.o_score !== 8'd20 || bus.o_level !== 2'd3) begin errors++; $display("[TB] FAIL eat20: got score=%0d level=%0d want 20 3", bus.o_score, bus.o_level); end
        framesToTick(n);
        checks++; if (n !== 7) begin errors++; $display("[TB] FAIL level3_period: got %0d want 7", n); end
        // Eats while paused still count.
        bus.i_pause = 1'b1;
        @(negedge clk);
        pulseEat(20);
        checks++; if (bus.o_score !== 8'd40 || bus.o_level !== 2'd3) begin errors++; $display("[TB] FAIL eat40_paused: got score=%0d level=%0d want 40 3", bus.o_score, bus.o_level); end
        bus.i_pause = 1'b0;
        @(negedge clk);
        bus.i_pause = 1'b1;
        @(negedge clk);
        bus.i_pause = 1'b0;
        @(negedge clk);
        checks++; if (bus.o_running !== 1'b1) begin errors++; $display("[TB] FAIL eat_unpause: got %b want 1", bus.o_running); end
    endtask

    task automatic test_lose_lives();
        for (int k = 0; k < 2; k++) begin
            pulseFailure();
            checks++; if (bus.o_lose_life !== 1'b1 || bus.o_lives !== 2'(2 - k) || bus.o_running !== 1'b0) begin errors++; $display("[TB] FAIL lose_life_%0d: got pulse=%b lives=%0d run=%b want 1 %0d 0", k, bus.o_lose_life, bus.o_lives, bus.o_running, 2 - k); end
            @(negedge clk);
            checks++; if (bus.o_lose_life !== 1'b0) begin errors++; $display("[TB] FAIL lose_life_pulse_%0d: got %b want 0", k, bus.o_lose_life); end
            repeat (59) pulseVsync();
            pulseStart();
            checks++; if (bus.o_running !== 1'b0) begin errors++; $display("[TB] FAIL respawn_hold_%0d: got %b want 0", k, bus.o_running); end
            pulseVsync();
            pulseStart();
            checks++; if (bus.o_running !== 1'b1) begin errors++; $display("[TB] FAIL respawn_restart_%0d: got %b want 1", k, bus.o_running); end
        end
        repeat (7) pulseVsync();
        checks++; if (bus.o_tick !== 1'b1) begin errors++; $display("[TB] FAIL after_respawn_tick: got %b want 1", bus.o_tick); end
        pulseFailure();
        checks++; if (bus.o_failure !== 1'b1 || bus.o_lives !== 2'd0 || bus.o_tick !== 1'b0) begin errors++; $display("[TB] FAIL game_over: got over=%b lives=%0d tick=%b want 1 0 0", bus.o_failure, bus.o_lives, bus.o_tick); end
        checks++; if (bus.o_high_score !== 8'd40 || bus.o_lose_life !== 1'b0) begin errors++; $display("[TB] FAIL over_high: got high=%0d lose=%b want 40 0", bus.o_high_score, bus.o_lose_life); end
        pulseStart();
        checks++; if (bus.o_failure !== 1'b1 || bus.o_running !== 1'b0) begin errors++; $display("[TB] FAIL over_terminal: got over=%b run=%b want 1 0", bus.o_failure, bus.o_running); end
    endtask

    task automatic test_win();
        bus.i_restart = 1'b1;
        @(negedge clk);
        bus.i_restart = 1'b0;
        checks++; if (bus.o_score !== 8'd0 || bus.o_lives !== 2'd3 || bus.o_level !== 2'd0 || bus.o_high_score !== 8'd40 || bus.o_failure !== 1'b0) begin errors++; $display("[TB] FAIL restart_after_over: got score=%0d lives=%0d level=%0d high=%0d over=%b want 0 3 0 40 0", bus.o_score, bus.o_lives, bus.o_level, bus.o_high_score, bus.o_failure); end
        pulseStart();
        pulseEat(8);
        bus.i_snake_success = 1'b1;
        bus.i_snake_failure = 1'b1;
        bus.i_eat           = 1'b1;
        @(negedge clk);
        bus.i_snake_success = 1'b0;
        bus.i_snake_failure = 1'b0;
        bus.i_eat           = 1'b0;
        checks++; if (bus.o_success !== 1'b1 || bus.o_failure !== 1'b0 || bus.o_running !== 1'b0) begin errors++; $display("[TB] FAIL win_priority: got win=%b over=%b run=%b want 1 0 0", bus.o_success, bus.o_failure, bus.o_running); end
        checks++; if (bus.o_lives !== 2'd3 || bus.o_score !== 8'd9 || bus.o_high_score !== 8'd40) begin errors++; $display("[TB] FAIL win_counts: got lives=%0d score=%0d high=%0d want 3 9 40", bus.o_lives, bus.o_score, bus.o_high_score); end
    endtask

    task automatic test_restart_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.o_high_score !== 8'd0 || bus.o_success !== 1'b0) begin errors++; $display("[TB] FAIL rst_clears_high: got high=%0d win=%b want 0 0", bus.o_high_score, bus.o_success); end
        pulseStart();
        pulseEat(9);
        loseLifeAndRespawn();
        loseLifeAndRespawn();
        pulseFailure();
        checks++; if (bus.o_failure !== 1'b1 || bus.o_high_score !== 8'd9 || bus.o_score !== 8'd9) begin errors++; $display("[TB] FAIL over_score9: got over=%b high=%0d score=%0d want 1 9 9", bus.o_failure, bus.o_high_score, bus.o_score); end
        bus.i_pause   = 1'b1;
        bus.i_restart = 1'b1;
        @(negedge clk);
        bus.i_restart = 1'b0;
        checks++; if (bus.o_score !== 8'd0 || bus.o_lives !== 2'd3 || bus.o_high_score !== 8'd9) begin errors++; $display("[TB] FAIL restart_keeps_high: got score=%0d lives=%0d high=%0d want 0 3 9", bus.o_score, bus.o_lives, bus.o_high_score); end
        pulseStart();
        checks++; if (bus.o_running !== 1'b1 || bus.o_paused !== 1'b0) begin errors++; $display("[TB] FAIL held_pause_no_toggle: got run=%b paused=%b want 1 0", bus.o_running, bus.o_paused); end
        bus.i_pause = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.o_high_score !== 8'd0 || bus.o_running !== 1'b0) begin errors++; $display("[TB] FAIL rst_after_restart: got high=%0d run=%b want 0 0", bus.o_high_score, bus.o_running); end
    endtask

    task automatic test_score_saturate();
        pulseStart();
        pulseEat(260);
        checks++; if (bus.o_score !== 8'd255 || bus.o_level !== 2'd3) begin errors++; $display("[TB] FAIL score_saturate: got score=%0d level=%0d want 255 3", bus.o_score, bus.o_level); end
    endtask

    initial begin
        rst                 = 1'b1;
        bus.i_restart       = 1'b0;
        bus.i_start         = 1'b0;
        bus.i_pause         = 1'b0;
        bus.i_vsync_pulse   = 1'b0;
        bus.i_tick_done     = 1'b0;
        bus.i_eat           = 1'b0;
        bus.i_snake_failure = 1'b0;
        bus.i_snake_success = 1'b0;
        @(negedge clk);
        test_reset();
        test_tick_period();
        test_pause();
        test_eat_levels();
        test_lose_lives();
        test_win();
        test_restart_rst();
        test_score_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
